// File: rtl/dmem_responder.sv
// dmem_responder: handshaked fixed-latency byte-addressed data RAM.
// Ports: clk/rst, req_* (valid/ready request), resp_* (valid/ready response).
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            type_q;
  logic                  sign_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  logic accept;
  logic exec;

  // Access fields: straight from the request when executing on the
  // accepting edge (LATENCY=1), otherwise from the captured copy.
  logic                  x_we;
  logic [ADDR_WIDTH-1:0] x_a0, x_a1, x_a2, x_a3;
  logic [DATA_WIDTH-1:0] x_wd;
  logic [1:0]            x_ty;
  logic                  x_sg;
  logic                  x_err;
  logic [7:0]            rb0, rb1, rb2, rb3;
  logic [DATA_WIDTH-1:0] ld;

  logic unused_addr;
  assign unused_addr = ^req_addr_i[DATA_WIDTH-1:ADDR_WIDTH];

  assign accept = req_valid_i & req_ready_o;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RESP;
            exec    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          exec    = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_rdata_o = rdata_q;
    resp_err_o   = err_q;
  end

  always_comb begin
    if (state_q == IDLE) begin
      x_we = req_we_i;
      x_a0 = req_addr_i[ADDR_WIDTH-1:0];
      x_wd = req_wdata_i;
      x_ty = req_type_i;
      x_sg = req_sign_i;
    end else begin
      x_we = we_q;
      x_a0 = addr_q;
      x_wd = wdata_q;
      x_ty = type_q;
      x_sg = sign_q;
    end
    x_a1 = x_a0 + ADDR_WIDTH'(1);
    x_a2 = x_a0 + ADDR_WIDTH'(2);
    x_a3 = x_a0 + ADDR_WIDTH'(3);
    x_err = (x_ty == 2'b11)
          | ((x_ty == 2'b01) & x_a0[0])
          | ((x_ty == 2'b10) & (x_a0[1:0] != 2'b00));
  end

  always_comb begin
    rb0 = mem[x_a0];
    rb1 = mem[x_a1];
    rb2 = mem[x_a2];
    rb3 = mem[x_a3];
    unique case (x_ty)
      2'b00:   ld = {{24{x_sg & rb0[7]}}, rb0};
      2'b01:   ld = {{16{x_sg & rb1[7]}}, rb1, rb0};
      default: ld = {rb3, rb2, rb1, rb0};
    endcase
  end

  // Request capture and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i[ADDR_WIDTH-1:0];
        wdata_q <= req_wdata_i;
        type_q  <= req_type_i;
        sign_q  <= req_sign_i;
      end
      if (exec) begin
        rdata_q <= (x_err | x_we) ? '0 : ld;
        err_q   <= x_err;
      end
    end
  end

  // RAM write; contents survive reset
  always_ff @(posedge clk) begin
    if (rst && exec && x_we && !x_err) begin
      mem[x_a0] <= x_wd[7:0];
      if (x_ty != 2'b00) mem[x_a1] <= x_wd[15:8];
      if (x_ty == 2'b10) begin
        mem[x_a2] <= x_wd[23:16];
        mem[x_a3] <= x_wd[31:24];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 2, 1 and 3.
// Three instances share clk/rst/request fields; sel picks the active one.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_type = 2'b00;
  logic        req_sign = 1'b0;
  logic        resp_ready = 1'b1;
  int          sel = 0;

  logic        rdy [3];
  logic        vld [3];
  logic [31:0] rdt [3];
  logic        err [3];

  logic        ready, valid, rerr;
  logic [31:0] rdata;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid && sel == 0), .req_ready_o(rdy[0]),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_type_i(req_type), .req_sign_i(req_sign),
    .resp_valid_o(vld[0]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdt[0]), .resp_err_o(err[0])
  );

  dmem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid && sel == 1), .req_ready_o(rdy[1]),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_type_i(req_type), .req_sign_i(req_sign),
    .resp_valid_o(vld[1]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdt[1]), .resp_err_o(err[1])
  );

  dmem_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid && sel == 2), .req_ready_o(rdy[2]),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_type_i(req_type), .req_sign_i(req_sign),
    .resp_valid_o(vld[2]), .resp_ready_i(resp_ready),
    .resp_rdata_o(rdt[2]), .resp_err_o(err[2])
  );

  always_comb begin
    ready = rdy[sel];
    valid = vld[sel];
    rdata = rdt[sel];
    rerr  = err[sel];
  end

  // One complete transaction with resp_ready held high.
  // n counts edges from acceptance (inclusive) until resp_valid is seen.
  task automatic do_req(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] ty,
                        input logic sg, output int n,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    sel = s; req_we = we; req_addr = a; req_wdata = wd;
    req_type = ty; req_sign = sg; req_valid = 1'b1; resp_ready = 1'b1;
    #1;
    nchk++;
    if (ready !== 1'b1) begin
      nerr++; $display("FAIL req_ready_before_accept: got %b want 1", ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    while (valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    rd = rdata; er = rerr;
    @(posedge clk); #1;
    nchk++;
    if (valid !== 1'b0 || ready !== 1'b1) begin
      nerr++;
      $display("FAIL one_cycle_resp: valid=%b ready=%b want 0/1", valid, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      nchk++;
      if (ready !== 1'b1 || valid !== 1'b0 || rdata !== 32'h0 || rerr !== 1'b0) begin
        nerr++;
        $display("FAIL reset_state[%0d]: rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                 s, ready, valid, rdata, rerr);
      end
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_word_round_trip();
    int n; logic [31:0] rd; logic er;
    do_req(0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 0, n, rd, er);
    nchk++;
    if (n !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      nerr++; $display("FAIL word_store: lat=%0d rd=%h err=%b want 2 0 0", n, rd, er);
    end
    do_req(0, 0, 32'h100, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (n !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      nerr++; $display("FAIL word_load: lat=%0d rd=%h err=%b want 2 deadbeef 0", n, rd, er);
    end
  endtask

  task automatic test_byte_ext();
    int n; logic [31:0] rd; logic er;
    do_req(0, 1, 32'h103, 32'h12345680, 2'b00, 0, n, rd, er);
    do_req(0, 0, 32'h103, 32'h0, 2'b00, 1, n, rd, er);
    nchk++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      nerr++; $display("FAIL byte_sext: rd=%h err=%b want ffffff80 0", rd, er);
    end
    do_req(0, 0, 32'h103, 32'h0, 2'b00, 0, n, rd, er);
    nchk++;
    if (rd !== 32'h00000080) begin
      nerr++; $display("FAIL byte_zext: rd=%h want 00000080", rd);
    end
    do_req(0, 0, 32'h100, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (rd !== 32'h80ADBEEF) begin
      nerr++; $display("FAIL byte_merge: rd=%h want 80adbeef", rd);
    end
    do_req(0, 0, 32'h100, 32'h0, 2'b01, 1, n, rd, er);
    nchk++;
    if (rd !== 32'hFFFFBEEF) begin
      nerr++; $display("FAIL half_sext: rd=%h want ffffbeef", rd);
    end
  endtask

  task automatic test_half_misalign();
    int n; logic [31:0] rd; logic er;
    do_req(0, 1, 32'h200, 32'h0BADF00D, 2'b10, 0, n, rd, er);
    do_req(0, 1, 32'h201, 32'h1234, 2'b01, 0, n, rd, er);
    nchk++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      nerr++; $display("FAIL half_misalign: err=%b rd=%h want 1 0", er, rd);
    end
    do_req(0, 0, 32'h200, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin
      nerr++; $display("FAIL misalign_nowrite: rd=%h want 0badf00d", rd);
    end
    do_req(0, 1, 32'h202, 32'h1234, 2'b01, 0, n, rd, er);
    do_req(0, 0, 32'h202, 32'h0, 2'b01, 1, n, rd, er);
    nchk++;
    if (rd !== 32'h00001234 || er !== 1'b0) begin
      nerr++; $display("FAIL half_load: rd=%h err=%b want 00001234 0", rd, er);
    end
    do_req(0, 0, 32'h102, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      nerr++; $display("FAIL word_misalign: err=%b rd=%h want 1 0", er, rd);
    end
    do_req(0, 0, 32'h100, 32'h0, 2'b11, 0, n, rd, er);
    nchk++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      nerr++; $display("FAIL reserved_type: err=%b rd=%h want 1 0", er, rd);
    end
  endtask

  task automatic test_backpressure();
    int n; logic [31:0] rd; logic er;
    @(negedge clk);
    sel = 0; req_we = 0; req_addr = 32'h100; req_type = 2'b10;
    req_sign = 0; req_valid = 1; resp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    n = 1;
    while (valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    nchk++;
    if (n !== 2) begin
      nerr++; $display("FAIL bp_latency: got %0d want 2", n);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_we = 1; req_addr = 32'h100; req_wdata = 32'h55555555;
      req_valid = 1;
      @(posedge clk); #1;
      nchk++;
      if (valid !== 1'b1 || rdata !== 32'h80ADBEEF || rerr !== 1'b0 || ready !== 1'b0) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: vld=%b rd=%h err=%b rdy=%b want 1 80adbeef 0 0",
                 i, valid, rdata, rerr, ready);
      end
    end
    @(negedge clk);
    req_valid = 0; resp_ready = 1;
    @(posedge clk); #1;
    nchk++;
    if (ready !== 1'b1 || valid !== 1'b0) begin
      nerr++; $display("FAIL bp_release: rdy=%b vld=%b want 1 0", ready, valid);
    end
    do_req(0, 0, 32'h100, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (rd !== 32'h80ADBEEF) begin
      nerr++; $display("FAIL bp_ignored_req: rd=%h want 80adbeef", rd);
    end
  endtask

  task automatic test_reset_mid_op();
    int n; logic [31:0] rd; logic er;
    do_req(2, 1, 32'h300, 32'h11112222, 2'b10, 0, n, rd, er);
    nchk++;
    if (n !== 3) begin
      nerr++; $display("FAIL lat3: got %0d want 3", n);
    end
    @(negedge clk);
    sel = 2; req_we = 1; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    req_type = 2'b10; req_valid = 1;
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    nchk++;
    if (ready !== 1'b1 || valid !== 1'b0 || rdata !== 32'h0 || rerr !== 1'b0) begin
      nerr++;
      $display("FAIL reset_wait: rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
               ready, valid, rdata, rerr);
    end
    @(negedge clk); rst = 1;
    do_req(2, 0, 32'h300, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (rd !== 32'h11112222 || n !== 3) begin
      nerr++; $display("FAIL reset_drops_store: rd=%h lat=%0d want 11112222 3", rd, n);
    end
    // Reset while a response is pending
    @(negedge clk);
    sel = 0; req_we = 0; req_addr = 32'h100; req_type = 2'b10;
    req_valid = 1; resp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    nchk++;
    if (valid !== 1'b0 || ready !== 1'b1 || rdata !== 32'h0) begin
      nerr++; $display("FAIL reset_resp: vld=%b rdy=%b rd=%h want 0 1 0", valid, ready, rdata);
    end
    @(negedge clk); rst = 1; resp_ready = 1;
  endtask

  task automatic test_latency_wrap();
    int n; logic [31:0] rd; logic er;
    do_req(1, 1, 32'h00020000, 32'hA5A55A5A, 2'b10, 0, n, rd, er);
    nchk++;
    if (n !== 1 || er !== 1'b0) begin
      nerr++; $display("FAIL lat1_store: lat=%0d err=%b want 1 0", n, er);
    end
    do_req(1, 0, 32'h0, 32'h0, 2'b10, 0, n, rd, er);
    nchk++;
    if (n !== 1 || rd !== 32'hA5A55A5A) begin
      nerr++; $display("FAIL wrap_load: lat=%0d rd=%h want 1 a5a55a5a", n, rd);
    end
    do_req(1, 0, 32'h00040003, 32'h0, 2'b00, 1, n, rd, er);
    nchk++;
    if (rd !== 32'hFFFFFFA5) begin
      nerr++; $display("FAIL wrap_byte: rd=%h want ffffffa5", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word_round_trip();
    test_byte_ext();
    test_half_misalign();
    test_backpressure();
    test_reset_mid_op();
    test_latency_wrap();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store interface; the core issues requests, this block serves them.
- Replaces the zero-latency combinational data memory with a handshaked, fixed-latency byte-addressed RAM.
- Supports byte/half/word accesses, sign/zero extension on loads, and misalignment error reporting.
- Used to exercise pipeline stalls: one outstanding request at a time.

Parameters:
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 17, byte-address bits decoded; RAM holds 2^ADDR_WIDTH bytes.
- LATENCY, 2, edges from request acceptance to response valid; legal values are 1 to 15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  DATA_WIDTH  byte address; bits at and above ADDR_WIDTH are ignored.
- req_wdata_i  in  DATA_WIDTH  store data; the low byte/half/word is used.
- req_type_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- req_sign_i  in  1  1 = sign-extend load, 0 = zero-extend.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  core accepts the response.
- resp_rdata_o  out  DATA_WIDTH  load result, extended; 0 for stores and errors.
- resp_err_o  out  1  misaligned or reserved-type access.

Behaviour:
- Reset (rst=0 at an edge) forces:
  - state to IDLE;
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0;
  - latency counter to 0.
- RAM contents are not reset.
- FSM states:
  - IDLE: req_ready_o=1. A request is accepted when req_valid_i & req_ready_o at an edge. All request fields are captured at that edge. Next state is WAIT, or RESP if LATENCY=1.
  - WAIT: req_ready_o=0. The counter loads LATENCY-1 at acceptance and decrements each edge. On the edge where it would reach 0, the state moves to RESP and the access executes.
  - RESP: resp_valid_o=1, req_ready_o=0. resp_rdata_o and resp_err_o are held stable until resp_valid_o & resp_ready_i at an edge. That edge returns the state to IDLE.
- Handshake timing:
  - resp_valid_o first rises exactly LATENCY edges after the accepting edge.
  - The earliest next acceptance is the edge after the response handshake.
  - req_ready_o is not asserted combinationally during RESP.
- Access execution happens once, on the edge entering RESP.
- Alignment errors:
  - half with addr[0]=1 → error;
  - word with addr[1:0]≠0 → error;
  - req_type 11 → error;
  - byte accesses are never misaligned.
- On error: no RAM write, resp_err_o=1, resp_rdata_o=0.
- Stores (little-endian):
  - byte writes wdata[7:0] at addr;
  - half writes wdata[15:0] at addr and addr+1;
  - word writes wdata[31:0] at addr through addr+3;
  - resp_rdata_o=0 and resp_err_o=0.
- Loads:
  - assemble bytes little-endian from the captured address;
  - byte/half results are extended to 32 bits per the captured sign bit;
  - word results are passed unchanged;
  - resp_err_o=0.
- Address wrap: the effective address is addr[ADDR_WIDTH-1:0]. Aligned accesses never cross the top of the RAM.
- Request inputs are ignored when req_ready_o=0. Changing them after acceptance has no effect.
- Reset mid-operation (WAIT or RESP) drops the pending request:
  - a store still in WAIT performs no write;
  - a response in RESP is discarded without a handshake.
- Reset takes priority over a simultaneous acceptance or response handshake.
- resp_ready_i may be held high permanently. The response then lasts exactly one cycle.

Test Plan:
- Word round trip: store word 0xDEADBEEF at 0x100, then load word 0x100 with LATENCY=2 → resp_valid_o rises 2 edges after each acceptance; load rdata=0xDEADBEEF, err=0.
- Byte extension: store byte 0x80 at 0x103, then load byte from 0x103 → sign=1 gives 0xFFFFFF80; sign=0 gives 0x00000080. The other bytes of word 0x100 are unchanged (reload word → 0x80ADBEEF).
- Half and misaligned: store half 0x1234 at 0x201 → err=1, rdata=0, and a word load of 0x200 returns the prior contents. Store half 0x1234 at 0x202, then load half 0x202 sign=1 → 0x00001234.
- Back-pressure: hold resp_ready_i=0 for 3 cycles during a load response → resp_valid_o, rdata and err are stable, req_ready_o=0, and a new req_valid_i is ignored. Raising resp_ready_i gives a handshake, and req_ready_o=1 the next cycle.
- Reset mid-WAIT: accept a store of 0xCAFEF00D at 0x300 with LATENCY=3, then drive rst=0 one edge later → outputs take their reset values, and a later load of 0x300 returns the old value, not 0xCAFEF00D.
- Latency and wrap: with LATENCY=1 and ADDR_WIDTH=17, store a word at 0x00020000 then load a word at 0x0 → same data, response 1 edge after acceptance.
